// File: rtl/des_pkg.sv
// Shared constants, state encoding and job record for the DES core arbiter.
package des_pkg;

    localparam int DES_BLK_W           = 64;
    localparam int DES_TIMEOUT_DEFAULT = 24;
    localparam int DES_NREQ            = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic [DES_BLK_W-1:0] key;
        logic [DES_BLK_W-1:0] data;
        logic                 decrypt;
    } des_job_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/des_core_arbiter_if.sv
// Requester job/response bundle plus the shared DES core handshake.
interface des_core_arbiter_if;
    import des_pkg::*;

    logic [DES_NREQ-1:0]                req_valid;
    logic [DES_NREQ-1:0]                req_ready;
    logic [DES_NREQ-1:0][DES_BLK_W-1:0] req_key;
    logic [DES_NREQ-1:0][DES_BLK_W-1:0] req_data;
    logic [DES_NREQ-1:0]                req_decrypt;
    logic [DES_NREQ-1:0]                rsp_valid;
    logic [DES_NREQ-1:0][DES_BLK_W-1:0] rsp_data;
    logic [DES_NREQ-1:0]                rsp_error;

    logic                               core_start;
    logic                               core_key_ready;
    logic                               core_data_ready;
    logic [DES_BLK_W-1:0]               core_key;
    logic [DES_BLK_W-1:0]               core_data;
    logic                               core_decrypt;
    logic                               core_done;
    logic                               core_error;
    logic [DES_BLK_W-1:0]               core_dout;
    logic                               busy;

    modport slave (
        input  req_valid, req_key, req_data, req_decrypt,
               core_done, core_error, core_dout,
        output req_ready, rsp_valid, rsp_data, rsp_error,
               core_start, core_key_ready, core_data_ready,
               core_key, core_data, core_decrypt, busy
    );

    modport master (
        output req_valid, req_key, req_data, req_decrypt,
               core_done, core_error, core_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
               core_start, core_key_ready, core_data_ready,
               core_key, core_data, core_decrypt, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational pick plus the last-grant pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_q;

    // Pointer resets to 1 so requester 0 wins the first contended grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

    assign grant_valid = |req;
    assign grant_idx   = (&req) ? ~last_q : req[1];

endmodule

// File: rtl/des_core_arbiter.sv
// Shares one DES core between two requesters: round-robin grant, single-cycle
// start pulse, bounded wait for the core, and per-requester sticky responses.
module des_core_arbiter
    import des_pkg::*;
#(
    parameter int TIMEOUT = DES_TIMEOUT_DEFAULT,
    parameter int NREQ    = DES_NREQ
) (
    input  logic              clk,
    input  logic              rst,
    des_core_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]                     state;
    logic [CNT_W-1:0]               wait_cnt;
    des_job_t                       job_q;
    logic                           owner_q;
    logic [NREQ-1:0]                rsp_error_q;
    logic [NREQ-1:0][DES_BLK_W-1:0] rsp_data_q;

    logic grant_valid;
    logic grant_idx;
    logic take;
    logic timed_out;

    assign take      = (state == ST_IDLE) && grant_valid && !rst;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req_valid),
        .advance     (take),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // wait_cnt counts cycles since core_start, so a timeout lands TIMEOUT cycles after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            job_q       <= '0;
            owner_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (grant_valid) begin
                        job_q.key     <= bus.req_key[grant_idx];
                        job_q.data    <= bus.req_data[grant_idx];
                        job_q.decrypt <= bus.req_decrypt[grant_idx];
                        owner_q       <= grant_idx;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.core_error) begin
                        rsp_data_q[owner_q]  <= '0;
                        rsp_error_q[owner_q] <= 1'b1;
                        state                <= ST_RESP;
                    end else if (bus.core_done) begin
                        rsp_data_q[owner_q]  <= bus.core_dout;
                        rsp_error_q[owner_q] <= 1'b0;
                        state                <= ST_RESP;
                    end else if (timed_out) begin
                        rsp_data_q[owner_q]  <= '0;
                        rsp_error_q[owner_q] <= 1'b1;
                        state                <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while rst is high so nothing leaks during reset.
    assign bus.req_ready       = take ? idx_to_onehot(grant_idx) : '0;
    assign bus.rsp_valid       = ((state == ST_RESP) && !rst) ? idx_to_onehot(owner_q) : '0;
    assign bus.rsp_data        = rst ? '0 : rsp_data_q;
    assign bus.rsp_error       = rst ? '0 : rsp_error_q;
    assign bus.core_start      = (state == ST_ISSUE) && !rst;
    assign bus.core_key_ready  = ((state == ST_ISSUE) || (state == ST_WAIT)) && !rst;
    assign bus.core_data_ready = ((state == ST_ISSUE) || (state == ST_WAIT)) && !rst;
    assign bus.core_key        = rst ? '0 : job_q.key;
    assign bus.core_data       = rst ? '0 : job_q.data;
    assign bus.core_decrypt    = job_q.decrypt && !rst;
    assign bus.busy            = (state != ST_IDLE) && !rst;

endmodule

// File: doc/des_core_arbiter.md
DES_CORE_ARBITER -- requirements
Module: des_core_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24, SHALL be the maximum core cycles allowed from core_start to core_done before abort.
REQ-002 Parameter NREQ, default 2, SHALL be the number of requesters; only 2 is supported.
REQ-003 clk  in  1  SHALL be the single system clock, rising edge.
REQ-004 rst  in  1  SHALL be the reset: one clock; reset is synchronous and active-high.
REQ-005 req_valid[i]  in  1 (i=0,1)  SHALL indicate that requester i presents a job.
REQ-006 req_ready[i]  out  1  SHALL indicate that the job of requester i is accepted this cycle.
REQ-007 req_key[i]  in  64  SHALL carry the DES key of requester i.
REQ-008 req_data[i]  in  64  SHALL carry the input block of requester i.
REQ-009 req_decrypt[i]  in  1  SHALL select the direction: 1 decrypt, 0 encrypt.
REQ-010 rsp_valid[i]  out  1  SHALL be the result strobe to requester i.
REQ-011 rsp_data[i]  out  64  SHALL carry the result block to requester i.
REQ-012 rsp_error[i]  out  1  SHALL flag a failed job for requester i.
REQ-013 core_start  out  1  SHALL be a one-cycle start pulse to the shared DES core.
REQ-014 core_key_ready, core_data_ready  out  1  SHALL be held high while the core operands are valid.
REQ-015 core_key, core_data  out  64  SHALL carry the registered operands; core_decrypt  out  1  SHALL carry the registered direction.
REQ-016 core_done, core_error  in  1  SHALL be the core completion and error pulses.
REQ-017 core_dout  in  64  SHALL be the core result, valid when core_done=1.
REQ-018 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, encoded in 2 bits.
REQ-020 IDLE: if any req_valid is high, the FSM SHALL grant one requester by round-robin, pulse req_ready for that requester for 1 cycle, latch key, data, decrypt and the grant index, and move to ISSUE.
REQ-021 Round-robin: the requester not granted last SHALL win when both are valid; after reset, requester 0 SHALL have priority.
REQ-022 ISSUE: core_start SHALL be 1 for exactly one cycle, core_key_ready and core_data_ready SHALL be 1, and the FSM SHALL move to WAIT.
REQ-023 WAIT: the timeout counter SHALL increment by 1 each cycle; the counter SHALL be wide enough to hold TIMEOUT without wrap.
REQ-024 WAIT exit on core_done=1: the FSM SHALL capture core_dout with error=0 and move to RESP.
REQ-025 WAIT exit on core_error=1: the FSM SHALL set error=1 with data 0 and move to RESP.
REQ-026 WAIT exit on counter==TIMEOUT: the FSM SHALL set error=1 with data 0 and move to RESP.
REQ-027 Simultaneous core_done and core_error SHALL resolve as an error.
REQ-028 Simultaneous core_done and timeout SHALL resolve as success.
REQ-029 RESP: rsp_valid SHALL be 1 for one cycle, to the granted requester only; the FSM SHALL then return to IDLE.
REQ-030 rsp_data and rsp_error SHALL hold their value until the next response to that requester.
REQ-031 Latency SHALL be 1 cycle from grant to core_start, and 1 cycle from core_done to rsp_valid.
REQ-032 Back-to-back: the earliest next grant SHALL be the cycle after RESP.
REQ-033 req_ready SHALL never assert outside IDLE.
REQ-034 A job SHALL never be dropped once accepted, except by reset.
REQ-035 core_done or core_error seen outside WAIT SHALL be ignored.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL enter IDLE, clear the counter, and set the last-grant pointer to 1 (so requester 0 wins next).
REQ-037 During and after reset, every output SHALL be 0: req_ready, rsp_valid, rsp_data, rsp_error, core_start, core_key_ready, core_data_ready, core_key, core_data, core_decrypt and busy.
REQ-038 A reset during WAIT SHALL abandon the job with no response; a late core_done after reset SHALL be ignored.

Structure
REQ-039 The shared package des_pkg SHALL hold the state encoding, DES_BLK_W=64 and the default TIMEOUT.
REQ-040 The grant logic SHALL be one sub-module, rr_arbiter2, which is combinational plus the pointer register; all other logic SHALL be in this module.

Verification
REQ-041 Single job: req0 with key 133457799BBCDFF1, data 0123456789ABCDEF, encrypt; core model returns 85E813540F0AB405 after 17 cycles -> rsp_valid[0] once, rsp_data[0]=85E813540F0AB405, rsp_error[0]=0.
REQ-042 Contention: req0 and req1 held valid for 3 jobs each -> grants follow 0,1,0,1,0,1, with every response routed to the correct requester.
REQ-043 Timeout: the core never returns done -> rsp_error=1 and rsp_data=0 exactly TIMEOUT+1 cycles after core_start; the next job is granted normally.
REQ-044 Core error and done pulsed in the same cycle -> rsp_error=1.
REQ-045 rst asserted in WAIT, then core_done pulses 3 cycles later -> no rsp_valid, all outputs 0, and req0 gets the next grant.
REQ-046 Stray core_done pulsed in IDLE -> no output change.
